// File: rtl/mem_arb_pkg.sv
// Shared constants for the I/D memory arbiter: default widths, FSM state codes,
// and the saturating increment used by the completion counters.
// Pure declarations; no logic, no latency, no flow control.
package mem_arb_pkg;

  localparam int DEF_AW = 28;
  localparam int DEF_DW = 128;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto one shared block memory, round-robin on ties.
// Latency: strobe 1 cycle after the request, ready 1 cycle after mem_ready; min 3 cycles per transaction.
// Backpressure: requests are not acknowledged until the ready pulse; inputs ignored outside IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [15:0]   i_cnt,
  output logic [15:0]   d_cnt
);

  logic [1:0] state;
  logic       last_i;   // 1 when the most recent grant went to the I side
  logic       req_i;
  logic       req_d;
  logic       pick_d;

  // Lone requester wins; on a tie the side not granted last wins.
  always_comb begin
    req_i  = i_read;
    req_d  = d_read | d_write;
    pick_d = req_d & (~req_i | last_i);
  end

  // Main FSM: grant, hold latched command on the memory bus, capture read data, pulse ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      last_i    <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_d) begin
            state     <= S_GRANT_D;
            last_i    <= 1'b0;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // A simultaneous read+write request is treated as a write.
            mem_write <= d_write;
            mem_read  <= ~d_write;
          end else if (req_i) begin
            state     <= S_GRANT_I;
            last_i    <= 1'b1;
            mem_addr  <= i_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
          end
        end
        S_GRANT_I: begin
          if (mem_ready) begin
            i_rdata  <= mem_rdata;
            mem_read <= 1'b0;
            i_ready  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_GRANT_D: begin
          if (mem_ready) begin
            // The strobe registers still carry the op type here.
            if (mem_read) d_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_ready   <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Completion counters advance once per ready pulse and saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_cnt <= '0;
      d_cnt <= '0;
    end else begin
      if (i_ready) i_cnt <= sat_inc(i_cnt);
      if (d_ready) d_cnt <= sat_inc(d_cnt);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random traffic against a transaction-level model.
// Memory responder is behavioural with programmable latency and optional stray mem_ready.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [15:0]   i_cnt;
  logic [15:0]   d_cnt;

  int total = 0;
  int bad   = 0;

  // Responder controls
  int            resp_lat  = 1;
  bit            spur_en   = 0;
  bit            use_fixed = 0;
  logic [DW-1:0] fixed_data;
  logic [DW-1:0] last_resp;

  // Transaction-level model state
  bit            m_last_i;
  logic [15:0]   m_icnt, m_dcnt;
  logic [DW-1:0] m_irdata, m_drdata;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_dw();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [15:0] sat1(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Memory model: mem_ready after resp_lat strobe cycles, fresh data each response.
  initial begin
    int rcnt;
    rcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    last_resp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read || mem_write) begin
        if (rcnt >= resp_lat - 1) begin
          mem_ready = 1'b1;
          mem_rdata = use_fixed ? fixed_data : rand_dw();
          last_resp = mem_rdata;
          rcnt = 0;
        end else begin
          mem_ready = 1'b0;
          rcnt++;
        end
      end else begin
        mem_ready = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        mem_rdata = rand_dw();
        rcnt = 0;
      end
    end
  end

  // Exclusivity of strobes and of ready pulses, every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (mem_read && mem_write) begin
        bad++;
        $display("FAIL both_strobes @%0t: read=%b write=%b want not both", $time, mem_read, mem_write);
      end
      total++;
      if (i_ready && d_ready) begin
        bad++;
        $display("FAIL both_ready @%0t: i=%b d=%b want not both", $time, i_ready, d_ready);
      end
    end
  end

  task automatic model_reset();
    m_last_i = 1'b1;
    m_icnt   = '0;
    m_dcnt   = '0;
    m_irdata = '0;
    m_drdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; spur_en = 0; use_fixed = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Drive one request pattern and observe the resulting bus transaction and ready pulse.
  // who: 0 timeout, 1 I, 2 D, 3 both readies. rdy: cycles ready stayed high (1 or 2).
  task automatic do_txn(input bit ir, input bit dr, input bit dw,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input int drop_after,
                        output int who, output int scyc, output bit sr, output bit sw,
                        output logic [AW-1:0] sa, output logic [DW-1:0] swd,
                        output bit hold_ok, output int rdy);
    @(negedge clk);
    i_read = ir; d_read = dr; d_write = dw; i_addr = ia; d_addr = da; d_wdata = wd;
    who = 0; scyc = 0; sr = 0; sw = 0; sa = '0; swd = '0; hold_ok = 1; rdy = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (scyc == 0) begin
          sr = mem_read; sw = mem_write; sa = mem_addr; swd = mem_wdata;
        end else if (mem_addr !== sa || mem_wdata !== swd || mem_read !== sr || mem_write !== sw) begin
          hold_ok = 0;
        end
        scyc++;
        if (scyc == drop_after) begin
          i_read = 0; d_read = 0; d_write = 0;
        end
      end
      if (i_ready || d_ready) begin
        who = (i_ready && d_ready) ? 3 : (i_ready ? 1 : 2);
        i_read = 0; d_read = 0; d_write = 0;
        @(negedge clk);
        rdy = (i_ready || d_ready) ? 2 : 1;
        break;
      end
    end
    i_read = 0; d_read = 0; d_write = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #1;
    total++;
    if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0000", {mem_read, mem_write, i_ready, d_ready});
    end
    total++;
    if ({i_cnt, d_cnt} !== 32'h0) begin
      bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", i_cnt, d_cnt);
    end
    total++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      bad++; $display("FAIL reset_rdata: got %h/%h want 0", i_rdata, d_rdata);
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_bus: got %h/%h want 0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_i_read();
    int who, scyc, rdy; bit sr, sw, hold; logic [AW-1:0] sa; logic [DW-1:0] swd;
    resp_lat = 4; use_fixed = 1;
    fixed_data = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEADBEEF};
    do_txn(1, 0, 0, 28'h0000010, '0, '0, 1, who, scyc, sr, sw, sa, swd, hold, rdy);
    use_fixed = 0;
    total++;
    if (who !== 1) begin bad++; $display("FAIL iread_who: got %0d want 1", who); end
    total++;
    if (scyc !== 4 || sr !== 1 || sw !== 0) begin
      bad++; $display("FAIL iread_strobe: got cyc=%0d r=%b w=%b want 4,1,0", scyc, sr, sw);
    end
    total++;
    if (sa !== 28'h0000010 || !hold) begin
      bad++; $display("FAIL iread_addr: got %h hold=%b want 0000010 held", sa, hold);
    end
    total++;
    if (rdy !== 1) begin bad++; $display("FAIL iread_pulse: got %0d cycles want 1", rdy); end
    m_irdata = fixed_data; m_icnt = sat1(m_icnt); m_last_i = 1;
    total++;
    if (i_rdata !== m_irdata) begin bad++; $display("FAIL iread_data: got %h want %h", i_rdata, m_irdata); end
    total++;
    if (i_cnt !== 16'd1) begin bad++; $display("FAIL iread_cnt: got %0d want 1", i_cnt); end
  endtask

  task automatic test_d_write();
    int who, scyc, rdy; bit sr, sw, hold; logic [AW-1:0] sa; logic [DW-1:0] swd, wd;
    wd = {96'hA5A5_5A5A_0F0F_F0F0_1234_5678, 32'h00000168};
    resp_lat = $urandom_range(1, 5);
    do_txn(0, 0, 1, '0, 28'h00000FF, wd, 1, who, scyc, sr, sw, sa, swd, hold, rdy);
    total++;
    if (who !== 2 || rdy !== 1) begin bad++; $display("FAIL dwr_ready: got who=%0d cyc=%0d want 2,1", who, rdy); end
    total++;
    if (sw !== 1 || sr !== 0 || scyc !== resp_lat) begin
      bad++; $display("FAIL dwr_strobe: got w=%b r=%b cyc=%0d want 1,0,%0d", sw, sr, scyc, resp_lat);
    end
    total++;
    if (sa !== 28'h00000FF || swd !== wd || !hold) begin
      bad++; $display("FAIL dwr_bus: got %h %h hold=%b want 00000ff %h", sa, swd, hold, wd);
    end
    m_dcnt = sat1(m_dcnt); m_last_i = 0;
    total++;
    if (d_rdata !== m_drdata) begin bad++; $display("FAIL dwr_rdata: got %h want %h", d_rdata, m_drdata); end
    total++;
    if (d_cnt !== m_dcnt) begin bad++; $display("FAIL dwr_cnt: got %0d want %0d", d_cnt, m_dcnt); end
  endtask

  task automatic test_drop();
    int who, scyc, rdy; bit sr, sw, hold; logic [AW-1:0] sa; logic [DW-1:0] swd;
    resp_lat = 5;
    do_txn(0, 1, 0, '0, 28'h0ABCDE1, '0, 2, who, scyc, sr, sw, sa, swd, hold, rdy);
    m_drdata = last_resp; m_dcnt = sat1(m_dcnt); m_last_i = 0;
    total++;
    if (who !== 2 || scyc !== 5 || rdy !== 1) begin
      bad++; $display("FAIL drop_done: got who=%0d cyc=%0d rdy=%0d want 2,5,1", who, scyc, rdy);
    end
    total++;
    if (d_rdata !== m_drdata) begin bad++; $display("FAIL drop_data: got %h want %h", d_rdata, m_drdata); end
    total++;
    if (d_cnt !== m_dcnt) begin bad++; $display("FAIL drop_cnt: got %0d want %0d", d_cnt, m_dcnt); end
  endtask

  task automatic test_random();
    int who, scyc, rdy, ew; bit sr, sw, hold, ewr; logic [AW-1:0] sa, ia, da, ea;
    logic [DW-1:0] swd, wd; logic [2:0] p;
    spur_en = 1;
    for (int k = 0; k < 40; k++) begin
      p = 3'($urandom_range(1, 7));
      ia = AW'($urandom()); da = AW'($urandom()); wd = rand_dw();
      resp_lat = $urandom_range(1, 4);
      // Winner: lone requester, else whoever was not granted last.
      if (p[0] && (p[1] || p[2])) ew = m_last_i ? 2 : 1;
      else ew = p[0] ? 1 : 2;
      ewr = (ew == 2) && p[2];
      ea  = (ew == 1) ? ia : da;
      do_txn(p[0], p[1], p[2], ia, da, wd, 1, who, scyc, sr, sw, sa, swd, hold, rdy);
      m_last_i = (ew == 1);
      if (ew == 1) begin m_irdata = last_resp; m_icnt = sat1(m_icnt); end
      else begin
        if (!ewr) m_drdata = last_resp;
        m_dcnt = sat1(m_dcnt);
      end
      total++;
      if (who !== ew || rdy !== 1) begin
        bad++; $display("FAIL rand_who[%0d]: got %0d/%0d want %0d/1", k, who, rdy, ew);
      end
      total++;
      if (sw !== ewr || sr !== !ewr || scyc !== resp_lat || sa !== ea || !hold) begin
        bad++; $display("FAIL rand_bus[%0d]: got w=%b r=%b cyc=%0d a=%h want w=%b cyc=%0d a=%h", k, sw, sr, scyc, sa, ewr, resp_lat, ea);
      end
      if (ewr) begin
        total++;
        if (swd !== wd) begin bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", k, swd, wd); end
      end
      total++;
      if (i_rdata !== m_irdata || d_rdata !== m_drdata) begin
        bad++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", k, i_rdata, d_rdata, m_irdata, m_drdata);
      end
      total++;
      if (i_cnt !== m_icnt || d_cnt !== m_dcnt) begin
        bad++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", k, i_cnt, d_cnt, m_icnt, m_dcnt);
      end
    end
    spur_en = 0;
  endtask

  task automatic test_tie();
    int order[$]; int n; int exp_w;
    do_reset();
    resp_lat = 2;
    @(negedge clk);
    i_read = 1; d_read = 1; i_addr = 28'h0000111; d_addr = 28'h0000222;
    n = 0;
    for (int c = 0; c < 400 && n < 6; c++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        order.push_back(i_ready ? 1 : 2);
        if (i_ready) begin
          total++;
          if (i_rdata !== last_resp) begin bad++; $display("FAIL tie_idata[%0d]: got %h want %h", n, i_rdata, last_resp); end
        end else begin
          total++;
          if (d_rdata !== last_resp) begin bad++; $display("FAIL tie_ddata[%0d]: got %h want %h", n, d_rdata, last_resp); end
        end
        n++;
      end
    end
    i_read = 0; d_read = 0;
    @(negedge clk);
    total++;
    if (order.size() !== 6) begin bad++; $display("FAIL tie_count: got %0d want 6", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      exp_w = m_last_i ? 2 : 1;
      total++;
      if (order[k] !== exp_w) begin bad++; $display("FAIL tie_order[%0d]: got %0d want %0d", k, order[k], exp_w); end
      m_last_i = (exp_w == 1);
      if (exp_w == 1) m_icnt = sat1(m_icnt); else m_dcnt = sat1(m_dcnt);
    end
    total++;
    if (i_cnt !== m_icnt || d_cnt !== m_dcnt) begin
      bad++; $display("FAIL tie_cnt: got %0d/%0d want %0d/%0d", i_cnt, d_cnt, m_icnt, m_dcnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen; int pulses;
    do_reset();
    resp_lat = 30;
    @(negedge clk);
    i_read = 1; i_addr = 28'h0777777;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_read) seen = 1;
    end
    total++;
    if (seen !== 1) begin bad++; $display("FAIL rmid_grant: got no strobe want mem_read"); end
    @(negedge clk);
    i_read = 0;
    rst = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL rmid_strobe: got %b%b want 00", mem_read, mem_write);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i_ready || d_ready || mem_read || mem_write) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL rmid_ready: got %0d active cycles want 0", pulses); end
    total++;
    if (i_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", i_cnt); end
  endtask

  task automatic test_sat();
    int who, scyc, rdy; bit sr, sw, hold; logic [AW-1:0] sa; logic [DW-1:0] swd;
    do_reset();
    @(negedge clk);
    force dut.i_cnt = 16'hFFFE;
    #1;
    release dut.i_cnt;
    m_icnt = 16'hFFFE;
    resp_lat = 1;
    for (int k = 0; k < 3; k++) begin
      do_txn(1, 0, 0, AW'($urandom()), '0, '0, 1, who, scyc, sr, sw, sa, swd, hold, rdy);
      m_icnt = sat1(m_icnt);
      total++;
      if (who !== 1 || i_cnt !== m_icnt) begin
        bad++; $display("FAIL sat_cnt[%0d]: got who=%0d cnt=%h want 1,%h", k, who, i_cnt, m_icnt);
      end
    end
    total++;
    if (d_cnt !== 16'd0) begin bad++; $display("FAIL sat_dcnt: got %0d want 0", d_cnt); end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_drop();
    test_random();
    test_tie();
    test_reset_mid();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning):
- AW, 28, memory block-address width.
- DW, 128, block data width (four 32-bit words).
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache block read request.
- i_addr  in  AW  I-cache block address.
- i_ready  out  1  I-cache completion pulse.
- i_rdata  out  DW  I-cache read data.
- d_read  in  1  D-cache block read request.
- d_write  in  1  D-cache block write request.
- d_addr  in  AW  D-cache block address.
- d_wdata  in  DW  D-cache write data.
- d_ready  out  1  D-cache completion pulse.
- d_rdata  out  DW  D-cache read data.
- mem_read  out  1  shared memory read strobe.
- mem_write  out  1  shared memory write strobe.
- mem_addr  out  AW  shared memory address.
- mem_wdata  out  DW  shared memory write data.
- mem_rdata  in  DW  shared memory read data.
- mem_ready  in  1  shared memory completion.
- i_cnt  out  16  count of completed I-cache transactions.
- d_cnt  out  16  count of completed D-cache transactions.

Function
REQ-003 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D and DONE.
REQ-004 In IDLE, the request sets are: the I request is i_read; the D request is d_read or d_write.
REQ-005 In IDLE, if exactly one request is present, the FSM SHALL move to that requester's GRANT state.
REQ-006 If both requests are present in IDLE, the requester not granted last SHALL win; after reset, the D-cache wins the first tie.
REQ-007 On the grant edge, the block SHALL latch address, write data and op type into registers; request inputs SHALL be ignored until the next IDLE.
REQ-008 If d_read and d_write are both high at grant, the block SHALL perform a write.
REQ-009 mem_read/mem_write SHALL be driven from registers, asserted from the cycle after the request is seen in IDLE until the cycle mem_ready is sampled high (latency 1 cycle).
REQ-010 mem_addr and mem_wdata SHALL hold the latched values throughout GRANT.
REQ-011 On mem_ready in GRANT_x, the block SHALL register mem_rdata into x_rdata (reads only), deassert the mem strobes, and enter DONE.
REQ-012 In DONE, x_ready SHALL be high for exactly one cycle.
REQ-013 DONE SHALL always return to IDLE on the next edge; minimum transaction is 3 cycles (grant, mem_ready in the same cycle, DONE).
REQ-014 mem_ready sampled in IDLE or DONE SHALL be ignored.
REQ-015 A requester dropping its request mid-GRANT SHALL NOT abort the transaction; it still completes and pulses ready.
REQ-016 i_rdata and d_rdata SHALL hold their last value until overwritten by a later read for the same requester.
REQ-017 x_cnt SHALL increment by 1 in DONE for requester x and SHALL saturate at 16'hFFFF.
REQ-018 At most one mem strobe SHALL be high in any cycle.
REQ-019 i_ready and d_ready SHALL never be high together.

Reset
REQ-020 On rst low, asynchronously: state=IDLE, last-grant=I, all strobes and ready outputs 0, mem_addr/mem_wdata/i_rdata/d_rdata 0, i_cnt/d_cnt 0.
REQ-021 Reset mid-GRANT SHALL drop the in-flight transaction without any ready pulse.

Structure
REQ-022 State encodings and the AW/DW defaults SHALL reside in a shared package mem_arb_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; the saturating counter MAY be a local sat_cnt16 instance used twice.

Verification
REQ-024 The bench SHALL cover:
- I read only: i_read=1, i_addr=0x0000010, mem_ready after 4 cycles with mem_rdata=0x...DEADBEEF -> mem_read held 4 cycles, i_ready one pulse, i_rdata=0x...DEADBEEF, i_cnt=1.
- D write: d_write=1, d_addr=0x00000FF, d_wdata=0x...00000168 -> mem_write=1, mem_addr=0x00000FF, mem_wdata=0x...168, d_ready one pulse, d_rdata unchanged.
- Tie after reset: i_read=d_read=1 held -> D granted first, then I, then D alternating; never both strobes or both readies high.
- Requester drop: d_read deasserted two cycles into GRANT_D -> transaction completes, d_ready pulses, d_cnt increments.
- Reset mid-GRANT_I: rst low for 1 cycle -> strobes 0 immediately, no i_ready, i_cnt=0.
- Counter saturation: i_cnt preloaded to 0xFFFE by forced state, then 3 reads -> i_cnt=0xFFFF.
